// File: rtl/mem_stage_pkg.sv
// Shared constants and FSM encoding for the memory pipeline stage.
package mem_stage_pkg;
    localparam int DATA_W          = 16;
    localparam int REG_W           = 3;
    localparam int CNT_W           = 4;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd | wr;
    endfunction
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: valid and write_en pulse for one cycle per load,
// data fields hold their last loaded value otherwise.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              load_rdata,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] next_pc,
    input  logic [DATA_W-1:0] read_data,
    input  logic              is_mem_read,
    input  logic              is_mem_to_reg,
    input  logic              is_jal,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  write_reg,
    output logic              valid,
    output logic              write_en,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_next_pc,
    output logic [DATA_W-1:0] wb_read_data,
    output logic              wb_is_mem_read,
    output logic              wb_is_mem_to_reg,
    output logic              wb_is_jal,
    output logic [REG_W-1:0]  wb_write_reg
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid            <= 1'b0;
            write_en         <= 1'b0;
            wb_alu_result    <= '0;
            wb_next_pc       <= '0;
            wb_read_data     <= '0;
            wb_is_mem_read   <= 1'b0;
            wb_is_mem_to_reg <= 1'b0;
            wb_is_jal        <= 1'b0;
            wb_write_reg     <= '0;
        end else if (clear || !load) begin
            valid    <= 1'b0;
            write_en <= 1'b0;
        end else begin
            valid            <= 1'b1;
            write_en         <= reg_write;
            wb_alu_result    <= alu_result;
            wb_next_pc       <= next_pc;
            wb_is_mem_read   <= is_mem_read;
            wb_is_mem_to_reg <= is_mem_to_reg;
            wb_is_jal        <= is_jal;
            wb_write_reg     <= write_reg;
            if (load_rdata) begin
                wb_read_data <= read_data;
            end
        end
    end
endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU ops straight to writeback, sequences
// aligned loads/stores through a request/wait handshake, traps faults.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluResult,
    input  logic [DATA_W-1:0] ex_storeData,
    input  logic [DATA_W-1:0] ex_nextPC,
    input  logic              ex_isMemRead,
    input  logic              ex_isMemWrite,
    input  logic              ex_isMemToReg,
    input  logic              ex_isJAL,
    input  logic              ex_regWrite,
    input  logic [REG_W-1:0]  ex_writeReg,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_readData,
    output logic [DATA_W-1:0] wb_aluResult,
    output logic [DATA_W-1:0] wb_nextPC,
    output logic              wb_isMemRead,
    output logic              wb_isMemToReg,
    output logic              wb_isJAL,
    output logic              wb_writeEn,
    output logic [REG_W-1:0]  wb_writeReg,
    output logic              err
);
    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               discard;
    logic [DATA_W-1:0]  lat_alu, lat_store, lat_pc;
    logic               lat_rd, lat_wr, lat_m2r, lat_jal, lat_rw;
    logic [REG_W-1:0]   lat_reg;

    logic ex_mem_op, idle_go, accept_alu, accept_mem, misaligned, wait_done, from_wait;

    assign ex_mem_op  = is_mem_op(ex_isMemRead, ex_isMemWrite);
    assign idle_go    = (state == ST_IDLE) && ex_valid && !flush;
    assign accept_alu = idle_go && !ex_mem_op;
    assign accept_mem = idle_go && ex_mem_op && !ex_aluResult[0];
    assign misaligned = idle_go && ex_mem_op && ex_aluResult[0];
    assign wait_done  = (state == ST_WAIT) && mem_done;
    assign from_wait  = (state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            discard   <= 1'b0;
            err       <= 1'b0;
            lat_alu   <= '0;
            lat_store <= '0;
            lat_pc    <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_m2r   <= 1'b0;
            lat_jal   <= 1'b0;
            lat_rw    <= 1'b0;
            lat_reg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    discard  <= 1'b0;
                    if (accept_mem) begin
                        lat_alu   <= ex_aluResult;
                        lat_store <= ex_storeData;
                        lat_pc    <= ex_nextPC;
                        lat_rd    <= ex_isMemRead;
                        lat_wr    <= ex_isMemWrite;
                        lat_m2r   <= ex_isMemToReg;
                        lat_jal   <= ex_isJAL;
                        lat_rw    <= ex_regWrite;
                        lat_reg   <= ex_writeReg;
                        state     <= ST_REQ;
                    end else if (misaligned) begin
                        err   <= 1'b1;
                        state <= ST_FAULT;
                    end
                end
                ST_REQ: begin
                    wait_cnt <= '0;
                    state    <= flush ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    // A flush here cannot recall the bus request; remember to drop its result.
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (mem_done) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= ST_FAULT;
                    end else if (wait_cnt != {CNT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_FAULT;
            endcase
        end
    end

    // Stall covers the accepting cycle so upstream holds until the result returns.
    assign stall = rst_n && (((state == ST_IDLE) && ex_valid && ex_mem_op && !flush) ||
                             ((state == ST_REQ) && !flush) ||
                             ((state == ST_WAIT) && !mem_done) ||
                             (state == ST_FAULT));

    assign mem_rd    = (state == ST_REQ) && !flush && lat_rd;
    assign mem_wr    = (state == ST_REQ) && !flush && lat_wr && !lat_rd;
    assign mem_addr  = lat_alu;
    assign mem_wdata = lat_store;

    mem_wb_reg u_wb_reg (
        .clk              (clk),
        .rst_n            (rst_n),
        .load             (accept_alu || wait_done),
        .clear            (flush || (from_wait && discard)),
        .load_rdata       (wait_done && lat_rd),
        .alu_result       (from_wait ? lat_alu : ex_aluResult),
        .next_pc          (from_wait ? lat_pc : ex_nextPC),
        .read_data        (mem_rdata),
        .is_mem_read      (from_wait ? lat_rd : ex_isMemRead),
        .is_mem_to_reg    (from_wait ? lat_m2r : ex_isMemToReg),
        .is_jal           (from_wait ? lat_jal : ex_isJAL),
        .reg_write        (from_wait ? lat_rw : ex_regWrite),
        .write_reg        (from_wait ? lat_reg : ex_writeReg),
        .valid            (wb_valid),
        .write_en         (wb_writeEn),
        .wb_alu_result    (wb_aluResult),
        .wb_next_pc       (wb_nextPC),
        .wb_read_data     (wb_readData),
        .wb_is_mem_read   (wb_isMemRead),
        .wb_is_mem_to_reg (wb_isMemToReg),
        .wb_is_jal        (wb_isJAL),
        .wb_write_reg     (wb_writeReg)
    );
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// ALU and memory transactions against a transaction-level model.
module tb_mem_stage;
  logic        clk, rst_n;
  logic        ex_valid;
  logic [15:0] ex_aluResult, ex_storeData, ex_nextPC;
  logic        ex_isMemRead, ex_isMemWrite, ex_isMemToReg, ex_isJAL, ex_regWrite;
  logic [2:0]  ex_writeReg;
  logic        flush, stall;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr, mem_done;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [15:0] wb_readData, wb_aluResult, wb_nextPC;
  logic        wb_isMemRead, wb_isMemToReg, wb_isJAL, wb_writeEn;
  logic [2:0]  wb_writeReg;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Transaction-level model of the last value written back
  logic [15:0] exp_alu, exp_pc, exp_rdata;
  logic [2:0]  exp_reg;
  logic        exp_mr, exp_m2r, exp_jal;
  logic [53:0] wb_bus, exp_bus;
  logic [34:0] exp_q[$];

  assign wb_bus  = {wb_aluResult, wb_nextPC, wb_readData, wb_writeReg, wb_isMemRead, wb_isMemToReg, wb_isJAL};
  assign exp_bus = {exp_alu, exp_pc, exp_rdata, exp_reg, exp_mr, exp_m2r, exp_jal};

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .ex_aluResult(ex_aluResult), .ex_storeData(ex_storeData), .ex_nextPC(ex_nextPC),
    .ex_isMemRead(ex_isMemRead), .ex_isMemWrite(ex_isMemWrite), .ex_isMemToReg(ex_isMemToReg),
    .ex_isJAL(ex_isJAL), .ex_regWrite(ex_regWrite), .ex_writeReg(ex_writeReg),
    .flush(flush), .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_readData(wb_readData), .wb_aluResult(wb_aluResult),
    .wb_nextPC(wb_nextPC), .wb_isMemRead(wb_isMemRead), .wb_isMemToReg(wb_isMemToReg),
    .wb_isJAL(wb_isJAL), .wb_writeEn(wb_writeEn), .wb_writeReg(wb_writeReg), .err(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic set_ex(input logic v, input logic [15:0] alu, sd, pc,
                        input logic rd, wr, m2r, jal, rw, input logic [2:0] rg);
    ex_valid = v; ex_aluResult = alu; ex_storeData = sd; ex_nextPC = pc;
    ex_isMemRead = rd; ex_isMemWrite = wr; ex_isMemToReg = m2r;
    ex_isJAL = jal; ex_regWrite = rw; ex_writeReg = rg;
  endtask

  task automatic reset_model();
    exp_alu = '0; exp_pc = '0; exp_rdata = '0; exp_reg = '0;
    exp_mr = 1'b0; exp_m2r = 1'b0; exp_jal = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_done = 1'b0; mem_rdata = 16'h5A5A;
    set_ex(1'b1, 16'h0042, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5);
    reset_model();
    #3;
    checks++;
    if ({stall, mem_rd, mem_wr, err, wb_valid, wb_writeEn} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stall/rd/wr/err/wbv/wen=%b expected 000000",
               {stall, mem_rd, mem_wr, err, wb_valid, wb_writeEn});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    checks++;
    if (wb_bus !== 54'h0) begin
      errors++;
      $display("FAIL reset_wb: wb=%h expected 0", wb_bus);
    end
    @(posedge clk); @(posedge clk);
    ex_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic run_alu(input logic [15:0] alu, pc, input logic m2r, jal, rw,
                         input logic [2:0] rg, input string name);
    @(posedge clk); #1;
    set_ex(1'b1, alu, 16'($urandom), pc, 1'b0, 1'b0, m2r, jal, rw, rg);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall: stall=%b expected 0", name, stall);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_aluResult = 16'($urandom); ex_nextPC = 16'($urandom);
    exp_alu = alu; exp_pc = pc; exp_reg = rg; exp_mr = 1'b0; exp_m2r = m2r; exp_jal = jal;
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_writeEn} !== {1'b1, rw}) begin
      errors++;
      $display("FAIL %s_valid: wbv/wen=%b expected %b", name, {wb_valid, wb_writeEn}, {1'b1, rw});
    end
    checks++;
    if (wb_bus !== exp_bus) begin
      errors++;
      $display("FAIL %s_wb: wb=%h expected %h", name, wb_bus, exp_bus);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_writeEn} !== 2'b00 || wb_bus !== exp_bus) begin
      errors++;
      $display("FAIL %s_hold: wbv/wen=%b wb=%h expected 00 %h", name, {wb_valid, wb_writeEn}, wb_bus, exp_bus);
    end
  endtask

  // One aligned memory op; `waits` WAIT cycles pass without mem_done before it arrives.
  task automatic run_mem(input logic [15:0] addr, sd, pc, rdata, input logic rd, wr, m2r, jal, rw,
                         input logic [2:0] rg, input int waits, input string name);
    int stall_n, rd_n, wr_n;
    logic wb_seen, done_stall;
    logic [15:0] s_addr, s_wdata;
    stall_n = 0; rd_n = 0; wr_n = 0; wb_seen = 1'b0; done_stall = 1'b1;
    s_addr = '0; s_wdata = '0;
    @(posedge clk); #1;
    set_ex(1'b1, addr, sd, pc, rd, wr, m2r, jal, rw, rg);
    for (int c = 0; c <= waits + 2; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 1) begin ex_valid = 1'b0; ex_aluResult = 16'($urandom); ex_storeData = 16'($urandom); end
      if (c == waits + 2) begin mem_done = 1'b1; mem_rdata = rdata; end
      @(negedge clk);
      stall_n += int'(stall);
      rd_n += int'(mem_rd);
      wr_n += int'(mem_wr);
      if (mem_rd || mem_wr) begin s_addr = mem_addr; s_wdata = mem_wdata; end
      if (c >= 1 && wb_valid) wb_seen = 1'b1;
      if (c == waits + 2) done_stall = stall;
    end
    @(posedge clk); #1;
    mem_done = 1'b0; mem_rdata = 16'($urandom);
    exp_alu = addr; exp_pc = pc; exp_reg = rg; exp_mr = rd; exp_m2r = m2r; exp_jal = jal;
    if (rd) exp_rdata = rdata;
    @(negedge clk);
    checks++;
    if (stall_n != waits + 2) begin
      errors++;
      $display("FAIL %s_stall_len: stall cycles=%0d expected %0d", name, stall_n, waits + 2);
    end
    checks++;
    if (done_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_stall: stall=%b expected 0", name, done_stall);
    end
    checks++;
    if (rd_n != int'(rd) || wr_n != int'(wr && !rd)) begin
      errors++;
      $display("FAIL %s_strobes: rd=%0d wr=%0d expected %0d %0d", name, rd_n, wr_n, int'(rd), int'(wr && !rd));
    end
    checks++;
    if (s_addr !== addr || s_wdata !== sd) begin
      errors++;
      $display("FAIL %s_req: addr=%h wdata=%h expected %h %h", name, s_addr, s_wdata, addr, sd);
    end
    checks++;
    if (wb_seen || {wb_valid, wb_writeEn} !== {1'b1, rw}) begin
      errors++;
      $display("FAIL %s_valid: early=%b wbv/wen=%b expected 0 %b", name, wb_seen, {wb_valid, wb_writeEn}, {1'b1, rw});
    end
    checks++;
    if (wb_bus !== exp_bus) begin
      errors++;
      $display("FAIL %s_wb: wb=%h expected %h", name, wb_bus, exp_bus);
    end
  endtask

  task automatic test_alu();
    run_alu(16'h1234, 16'h0102, 1'b0, 1'b0, 1'b1, 3'd3, "alu_dir");
    for (int i = 0; i < 6; i++)
      run_alu(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), "alu_rnd");
  endtask

  task automatic test_mem();
    logic [15:0] a;
    int k;
    run_mem(16'h0040, 16'h0000, 16'h0200, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 3, "load_dir");
    run_mem(16'h0010, 16'h00FF, 16'h0204, 16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1, "store_dir");
    run_mem(16'h0080, 16'h7777, 16'h0208, 16'hCAFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 0, "rd_wr_prio");
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom); a[0] = 1'b0;
      k = $urandom_range(0, 2);
      run_mem(a, 16'($urandom), 16'($urandom), 16'($urandom), k != 1, k != 0, 1'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom), $urandom_range(0, 10), "mem_rnd");
    end
  endtask

  task automatic test_misaligned();
    int strobes;
    logic stall_ok, wbv;
    strobes = 0; stall_ok = 1'b1; wbv = 1'b0;
    @(posedge clk); #1;
    set_ex(1'b1, 16'h0003, 16'h4444, 16'h0300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 1) ex_valid = 1'b0;
      mem_done = (c == 3);
      @(negedge clk);
      strobes += int'(mem_rd | mem_wr);
      if (!stall) stall_ok = 1'b0;
      if (wb_valid) wbv = 1'b1;
    end
    checks++;
    if (err !== 1'b1 || strobes != 0) begin
      errors++;
      $display("FAIL misaligned_err: err=%b strobes=%0d expected 1 0", err, strobes);
    end
    checks++;
    if (!stall_ok || wbv) begin
      errors++;
      $display("FAIL misaligned_hold: stall_ok=%b wbv=%b expected 1 0", stall_ok, wbv);
    end
    @(posedge clk); #1;
    mem_done = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if ({err, stall} !== 2'b00) begin
      errors++;
      $display("FAIL misaligned_rst: err/stall=%b expected 00", {err, stall});
    end
    reset_model();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    int err_first;
    logic stall_ok, wbv;
    err_first = -1; stall_ok = 1'b1; wbv = 1'b0;
    @(posedge clk); #1;
    set_ex(1'b1, 16'h0100, 16'h0, 16'h0400, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
    for (int c = 0; c < 22; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 1) ex_valid = 1'b0;
      mem_done = (c == 20);
      @(negedge clk);
      if (err && err_first < 0) err_first = c;
      if (!stall) stall_ok = 1'b0;
      if (wb_valid) wbv = 1'b1;
    end
    checks++;
    if (err_first != 17) begin
      errors++;
      $display("FAIL timeout_cycle: err first at cycle %0d expected 17", err_first);
    end
    checks++;
    if (!stall_ok || wbv) begin
      errors++;
      $display("FAIL timeout_hold: stall_ok=%b wbv=%b expected 1 0", stall_ok, wbv);
    end
    @(posedge clk); #1;
    mem_done = 1'b0; rst_n = 1'b0;
    reset_model();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_wait();
    @(posedge clk); #1;
    set_ex(1'b1, 16'h0020, 16'h0, 16'h0500, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7);
    @(posedge clk); #1; ex_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, wb_valid, mem_rd, err} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_wait_now: stall/wbv/rd/err=%b expected 0000", {stall, wb_valid, mem_rd, err});
    end
    reset_model();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; mem_done = 1'b1; mem_rdata = 16'hF00D;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_stray_stall: stall=%b expected 0", stall);
    end
    @(posedge clk); #1; mem_done = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || wb_bus !== exp_bus) begin
      errors++;
      $display("FAIL rst_wait_stray_wb: wbv=%b wb=%h expected 0 %h", wb_valid, wb_bus, exp_bus);
    end
    run_alu(16'h0A0A, 16'h0B0B, 1'b0, 1'b1, 1'b1, 3'd2, "after_rst_wait");
  endtask

  task automatic test_flush();
    // Flush while a load is offered in IDLE
    @(posedge clk); #1;
    set_ex(1'b1, 16'h0060, 16'h0, 16'h0600, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_stall: stall=%b expected 0", stall);
    end
    @(posedge clk); #1; flush = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_rd, wb_valid, stall, err} !== 4'b0000) begin
      errors++;
      $display("FAIL flush_idle: rd/wbv/stall/err=%b expected 0000", {mem_rd, wb_valid, stall, err});
    end
    // Flush in REQ, then a stray mem_done outside WAIT
    @(posedge clk); #1;
    set_ex(1'b1, 16'h0062, 16'h0, 16'h0602, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
    @(posedge clk); #1; ex_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr} !== 2'b00) begin
      errors++;
      $display("FAIL flush_req_strobe: rd/wr=%b expected 00", {mem_rd, mem_wr});
    end
    @(posedge clk); #1; flush = 1'b0; mem_done = 1'b1; mem_rdata = 16'h1357;
    @(negedge clk);
    checks++;
    if ({wb_valid, stall} !== 2'b00) begin
      errors++;
      $display("FAIL flush_req: wbv/stall=%b expected 00", {wb_valid, stall});
    end
    @(posedge clk); #1; mem_done = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || wb_bus !== exp_bus) begin
      errors++;
      $display("FAIL flush_req_stray: wbv=%b wb=%h expected 0 %h", wb_valid, wb_bus, exp_bus);
    end
    // Flush in WAIT: transfer completes, result is dropped
    @(posedge clk); #1;
    set_ex(1'b1, 16'h0064, 16'h0, 16'h0604, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
    @(posedge clk); #1; ex_valid = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_wait_stall: stall=%b expected 1", stall);
    end
    @(posedge clk); #1; mem_done = 1'b1; mem_rdata = 16'h2468;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_done: stall=%b expected 0", stall);
    end
    @(posedge clk); #1; mem_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_writeEn} !== 2'b00 || wb_bus !== exp_bus) begin
      errors++;
      $display("FAIL flush_wait_wb: wbv/wen=%b wb=%h expected 00 %h", {wb_valid, wb_writeEn}, wb_bus, exp_bus);
    end
    run_alu(16'h0C0C, 16'h0D0D, 1'b1, 1'b0, 1'b0, 3'd6, "after_flush");
  endtask

  task automatic test_back_to_back();
    logic [34:0] item, got;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        @(negedge clk);
        item = exp_q.pop_front();
        got = {wb_aluResult, wb_nextPC, wb_writeReg};
        checks++;
        if (wb_valid !== 1'b1 || got !== item) begin
          errors++;
          $display("FAIL b2b: wbv=%b wb=%h expected 1 %h", wb_valid, got, item);
        end
        @(posedge clk); #1;
      end
      set_ex(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'($urandom));
      exp_q.push_back({ex_aluResult, ex_nextPC, ex_writeReg});
      exp_alu = ex_aluResult; exp_pc = ex_nextPC; exp_reg = ex_writeReg;
      exp_mr = 1'b0; exp_m2r = 1'b0; exp_jal = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stall: stall=%b expected 0", stall);
      end
    end
    @(posedge clk); #1; ex_valid = 1'b0;
    @(negedge clk);
    item = exp_q.pop_front();
    got = {wb_aluResult, wb_nextPC, wb_writeReg};
    checks++;
    if (wb_valid !== 1'b1 || got !== item) begin
      errors++;
      $display("FAIL b2b_last: wbv=%b wb=%h expected 1 %h", wb_valid, got, item);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_misaligned();
    test_timeout();
    test_reset_wait();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: ex_valid  in  1  execute stage presents an instruction this cycle.
REQ-004 SHALL have ports: ex_aluResult, ex_storeData, ex_nextPC  in  16 each  address/ALU value, store data, PC+2.
REQ-005 SHALL have ports: ex_isMemRead, ex_isMemWrite, ex_isMemToReg, ex_isJAL, ex_regWrite  in  1 each  decoded controls.
REQ-006 SHALL have ports: ex_writeReg  in  3  destination register.
REQ-007 SHALL have ports: flush  in  1  discard the instruction being accepted or in flight.
REQ-008 SHALL have ports: stall  out  1  upstream must hold its inputs.
REQ-009 SHALL have ports: mem_addr, mem_wdata  out  16 each  memory request address and store data.
REQ-010 SHALL have ports: mem_rd, mem_wr  out  1 each  one-cycle request strobes.
REQ-011 SHALL have ports: mem_done  in  1  memory completion pulse.
REQ-012 SHALL have ports: mem_rdata  in  16  read data, valid with mem_done.
REQ-013 SHALL have ports: wb_valid  out  1  registered writeback-stage inputs are valid.
REQ-014 SHALL have ports: wb_readData, wb_aluResult, wb_nextPC  out  16 each  registered writeback-stage inputs.
REQ-015 SHALL have ports: wb_isMemRead, wb_isMemToReg, wb_isJAL, wb_writeEn  out  1 each  registered writeback-stage controls.
REQ-016 SHALL have ports: wb_writeReg  out  3  registered destination register.
REQ-017 SHALL have ports: err  out  1  sticky fault flag.
REQ-018 SHALL have parameter: TIMEOUT, default 15, maximum cycles in WAIT before a fault.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, WAIT, FAULT.
REQ-020 IDLE, ex_valid=1, no memory operation: SHALL register all ex_* fields into wb_* on the next edge with wb_valid=1 (latency 1) and stall=0.
REQ-021 IDLE, ex_valid=1, memory operation, ex_aluResult[0]=0: SHALL latch fields, go to REQ, and assert stall.
REQ-022 REQ: SHALL drive mem_addr=latched aluResult, mem_wdata=latched storeData, and exactly one of mem_rd/mem_wr for one cycle, then go to WAIT.
REQ-023 WAIT: SHALL hold stall=1 and keep mem_rd=mem_wr=0.
REQ-024 WAIT with mem_done=1: SHALL load wb_readData=mem_rdata (loads only), load the other wb_* from latched fields, set wb_valid=1 for one cycle, and return to IDLE.
REQ-025 Stall SHALL deassert in the cycle mem_done is seen.
REQ-026 Memory latency SHALL be 2 + N cycles, where N = cycles spent in WAIT.
REQ-027 The WAIT counter SHALL be 4 bits and saturating; when it reaches TIMEOUT without mem_done, the FSM SHALL go to FAULT, set err, and produce wb_valid=0.
REQ-028 Misaligned access (ex_aluResult[0]=1 with read or write): SHALL issue no request, set err, go to FAULT, and produce no wb_valid.
REQ-029 FAULT: SHALL hold stall=1 and remain there until reset.
REQ-030 wb_writeEn SHALL equal the latched regWrite ANDed with the valid condition; when wb_valid=0, wb_writeEn SHALL be 0 and all other wb_* SHALL hold their previous values.
REQ-031 Simultaneous ex_isMemRead and ex_isMemWrite: read SHALL take priority and mem_wr SHALL stay 0.
REQ-032 flush in IDLE or REQ SHALL cancel the instruction: no strobe, wb_valid=0 next cycle, FSM to IDLE.
REQ-033 flush in WAIT SHALL let the FSM wait for mem_done, then discard the result (wb_valid=0).
REQ-034 mem_done outside WAIT SHALL be ignored.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, counter 0, err=0, stall=0, mem_rd=mem_wr=0, mem_addr=mem_wdata=0, wb_valid=0, wb_writeEn=0, and all wb_* data to 0.
REQ-036 Reset during WAIT SHALL abandon the request; a later stray mem_done SHALL be ignored.

Structure
REQ-037 The state encoding and the TIMEOUT default SHALL live in a shared package with the other pipeline constants.
REQ-038 The wb_* pipeline register SHALL be a sub-module, mem_wb_reg, with load and clear inputs.

Verification
REQ-039 ALU op, ex_aluResult=16'h1234, regWrite=1 -> next cycle wb_aluResult=16'h1234, wb_valid=1, wb_writeEn=1, stall=0.
REQ-040 Load at address 16'h0040, mem_done after 3 WAIT cycles with rdata=16'hBEEF -> mem_rd for 1 cycle, stall for 5 cycles, wb_readData=16'hBEEF, wb_valid=1.
REQ-041 Store at 16'h0010 with storeData=16'h00FF -> mem_wr=1 and mem_wdata=16'h00FF for one cycle, wb_writeEn=0.
REQ-042 Load at address 16'h0003 -> no mem_rd, err=1, stall stays 1 until rst_n pulse.
REQ-043 Load with no mem_done -> err=1 after 15 WAIT cycles, wb_valid never asserts.
REQ-044 rst_n low mid-WAIT, then mem_done -> FSM in IDLE, wb_valid=0, stall=0.
